// File: rtl/axis_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_if
// Brief    : AXI4-Stream bundle with master/slave modports.
// Revision : 1.0
// ============================================================================
interface axis_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = (DATA_WIDTH / 8),
    parameter int USER_WIDTH = 1
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_frame_gen.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_gen
// Brief    : AXI4-Stream frame generator, incrementing-byte payload per frame.
// Revision : 1.0
// ============================================================================
module axis_frame_gen #(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int USER_WIDTH  = 1,
    parameter int LEN_WIDTH   = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  wire                    clk,
    input  wire                    rst,
    input  wire [LEN_WIDTH-1:0]    cfg_frame_len,
    input  wire [COUNT_WIDTH-1:0]  cfg_frame_count,
    input  wire [7:0]              cfg_gap,
    input  wire [7:0]              cfg_seed,
    input  wire                    cfg_mark_bad,
    input  wire                    start,
    input  wire                    stop,
    axis_if.master                 m_axis,
    output logic                   status_busy,
    output logic                   status_done,
    output logic [COUNT_WIDTH-1:0] status_frames_sent
);

    localparam int OFF_W = LEN_WIDTH + 1;
    localparam logic [OFF_W-1:0] c_keep_step = OFF_W'(KEEP_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [LEN_WIDTH-1:0]   r_len, w_len_nxt;
    logic [COUNT_WIDTH-1:0] r_count, w_count_nxt;
    logic [7:0]             r_gap, w_gap_nxt;
    logic                   r_mark_bad, w_mark_bad_nxt;
    logic [7:0]             r_frame_base, w_frame_base_nxt;
    logic [OFF_W-1:0]       r_offset, w_offset_nxt;
    logic [7:0]             r_gap_cnt, w_gap_cnt_nxt;
    logic                   r_stop, w_stop_nxt;
    logic [COUNT_WIDTH-1:0] r_frames_sent, w_frames_sent_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;
    logic [DATA_WIDTH-1:0]  r_tdata, w_tdata_nxt;
    logic [KEEP_WIDTH-1:0]  r_tkeep, w_tkeep_nxt;
    logic                   r_tvalid, w_tvalid_nxt;
    logic                   r_tlast, w_tlast_nxt;
    logic [USER_WIDTH-1:0]  r_tuser, w_tuser_nxt;

    logic                   w_load;
    logic [OFF_W-1:0]       w_off_next;
    logic [7:0]             w_bld_base;
    logic [OFF_W-1:0]       w_bld_rem;
    logic                   w_bld_mark;
    logic [DATA_WIDTH-1:0]  w_beat_data;
    logic [KEEP_WIDTH-1:0]  w_beat_keep;
    logic                   w_beat_last;
    logic [USER_WIDTH-1:0]  w_beat_user;

    // Select which beat would be presented next: first beat of a new run,
    // next beat of the current frame, or first beat of the following frame.
    always_comb begin
        w_off_next = r_offset + c_keep_step;
        w_bld_base = r_frame_base;
        w_bld_rem  = {1'b0, r_len};
        w_bld_mark = r_mark_bad;
        case (r_state)
            S_IDLE: begin
                w_bld_base = cfg_seed;
                w_bld_rem  = {1'b0, cfg_frame_len};
                w_bld_mark = cfg_mark_bad;
            end
            S_SEND: begin
                if (r_tlast) begin
                    w_bld_base = r_frame_base + 8'd1;
                end else begin
                    w_bld_base = r_frame_base + 8'(w_off_next);
                    w_bld_rem  = {1'b0, r_len} - w_off_next;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_beat_data = '0;
        w_beat_keep = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (w_bld_rem > OFF_W'(i)) begin
                w_beat_data[8*i +: 8] = w_bld_base + 8'(i);
                w_beat_keep[i]        = 1'b1;
            end
        end
        w_beat_last = (w_bld_rem <= c_keep_step);
        w_beat_user = {USER_WIDTH{w_beat_last && w_bld_mark}};
        if (KEEP_ENABLE == 0) begin
            w_beat_keep = '1;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_len_nxt         = r_len;
        w_count_nxt       = r_count;
        w_gap_nxt         = r_gap;
        w_mark_bad_nxt    = r_mark_bad;
        w_frame_base_nxt  = r_frame_base;
        w_offset_nxt      = r_offset;
        w_gap_cnt_nxt     = r_gap_cnt;
        w_stop_nxt        = r_stop;
        w_frames_sent_nxt = r_frames_sent;
        w_busy_nxt        = r_busy;
        w_done_nxt        = 1'b0;
        w_tdata_nxt       = r_tdata;
        w_tkeep_nxt       = r_tkeep;
        w_tvalid_nxt      = r_tvalid;
        w_tlast_nxt       = r_tlast;
        w_tuser_nxt       = r_tuser;
        w_load            = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && (cfg_frame_len != '0)) begin
                    w_len_nxt         = cfg_frame_len;
                    w_count_nxt       = cfg_frame_count;
                    w_gap_nxt         = cfg_gap;
                    w_mark_bad_nxt    = cfg_mark_bad;
                    w_frame_base_nxt  = cfg_seed;
                    w_offset_nxt      = '0;
                    w_frames_sent_nxt = '0;
                    w_stop_nxt        = 1'b0;
                    w_busy_nxt        = 1'b1;
                    w_load            = 1'b1;
                    w_state_nxt       = S_SEND;
                end
            end
            S_SEND: begin
                if (stop) begin
                    w_stop_nxt = 1'b1;
                end
                if (r_tvalid && m_axis.tready) begin
                    if (r_tlast) begin
                        w_frames_sent_nxt = r_frames_sent + 1'b1;
                        w_offset_nxt      = '0;
                        w_frame_base_nxt  = r_frame_base + 8'd1;
                        if (((r_count != '0) && (w_frames_sent_nxt == r_count)) || r_stop || stop) begin
                            w_state_nxt  = S_IDLE;
                            w_tvalid_nxt = 1'b0;
                            w_busy_nxt   = 1'b0;
                            w_done_nxt   = 1'b1;
                        end else if (r_gap != 8'd0) begin
                            w_state_nxt   = S_GAP;
                            w_gap_cnt_nxt = r_gap - 8'd1;
                            w_tvalid_nxt  = 1'b0;
                        end else begin
                            w_load = 1'b1;
                        end
                    end else begin
                        w_offset_nxt = w_off_next;
                        w_load       = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (stop || r_stop) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else if (r_gap_cnt == 8'd0) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SEND;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_tvalid_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
            end
        endcase

        if (w_load) begin
            w_tdata_nxt  = w_beat_data;
            w_tkeep_nxt  = w_beat_keep;
            w_tlast_nxt  = w_beat_last;
            w_tuser_nxt  = w_beat_user;
            w_tvalid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_count       <= '0;
            r_gap         <= '0;
            r_mark_bad    <= 1'b0;
            r_frame_base  <= '0;
            r_offset      <= '0;
            r_gap_cnt     <= '0;
            r_stop        <= 1'b0;
            r_frames_sent <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_tdata       <= '0;
            r_tkeep       <= '1;
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
            r_tuser       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_len         <= w_len_nxt;
            r_count       <= w_count_nxt;
            r_gap         <= w_gap_nxt;
            r_mark_bad    <= w_mark_bad_nxt;
            r_frame_base  <= w_frame_base_nxt;
            r_offset      <= w_offset_nxt;
            r_gap_cnt     <= w_gap_cnt_nxt;
            r_stop        <= w_stop_nxt;
            r_frames_sent <= w_frames_sent_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_tdata       <= w_tdata_nxt;
            r_tkeep       <= w_tkeep_nxt;
            r_tvalid      <= w_tvalid_nxt;
            r_tlast       <= w_tlast_nxt;
            r_tuser       <= w_tuser_nxt;
        end
    end

    assign m_axis.tdata       = r_tdata;
    assign m_axis.tkeep       = r_tkeep;
    assign m_axis.tvalid      = r_tvalid;
    assign m_axis.tlast       = r_tlast;
    assign m_axis.tuser       = r_tuser;
    assign status_busy        = r_busy;
    assign status_done        = r_done;
    assign status_frames_sent = r_frames_sent;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_frame_gen
// Brief    : Scoreboard bench driving an 8-bit and a 32-bit frame generator.
// Revision : 1.0
// ============================================================================
module tb_axis_frame_gen;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    typedef struct {
        int len;
        int count;
        int gap;
        int seed;
        bit mark;
        bit w32;
        bit bp;
        bit stp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start8, start32, stop, tready, cfg_mark_bad;
    logic [15:0] cfg_frame_len, cfg_frame_count;
    logic [7:0]  cfg_gap, cfg_seed;
    logic        busy8, done8, busy32, done32;
    logic [15:0] fs8, fs32;
    bit          bp;

    always #5 clk = ~clk;

    axis_if #(.DATA_WIDTH(8),  .KEEP_WIDTH(1), .USER_WIDTH(1)) ax8 ();
    axis_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(1)) ax32 ();
    assign ax8.tready  = tready;
    assign ax32.tready = tready;

    axis_frame_gen #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .cfg_frame_len(cfg_frame_len), .cfg_frame_count(cfg_frame_count),
        .cfg_gap(cfg_gap), .cfg_seed(cfg_seed), .cfg_mark_bad(cfg_mark_bad),
        .start(start8), .stop(stop), .m_axis(ax8),
        .status_busy(busy8), .status_done(done8), .status_frames_sent(fs8)
    );

    axis_frame_gen #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst),
        .cfg_frame_len(cfg_frame_len), .cfg_frame_count(cfg_frame_count),
        .cfg_gap(cfg_gap), .cfg_seed(cfg_seed), .cfg_mark_bad(cfg_mark_bad),
        .start(start32), .stop(stop), .m_axis(ax32),
        .status_busy(busy32), .status_done(done32), .status_frames_sent(fs32)
    );

    beat_t q8[$];
    beat_t q32[$];
    int    hs_cnt[2];
    int    gap_seen[2];
    int    exp_gap[2];
    bit    after_last[2];
    bit    prev_stall[2];
    beat_t prev_beat[2];
    int    tests = 0;
    int    fails = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Byte k of frame n is (seed + n + k) mod 256, packed KEEP lanes per beat.
    task automatic push_run(input int d, input int len, input int frames, input int seed, input bit mark);
        int    kw;
        beat_t b;
        kw = d ? 4 : 1;
        for (int n = 0; n < frames; n++) begin
            for (int k0 = 0; k0 < len; k0 += kw) begin
                b = '0;
                for (int i = 0; i < kw; i++) begin
                    if (k0 + i < len) begin
                        b.data[8*i +: 8] = 8'((seed + n + k0 + i) & 255);
                        b.keep[i]        = 1'b1;
                    end
                end
                b.last = (k0 + kw >= len);
                b.user = b.last & mark;
                if (d != 0) q32.push_back(b);
                else        q8.push_back(b);
            end
        end
    endtask

    task automatic mon(input int d, input logic valid, input logic rdy, input logic done, input beat_t b);
        beat_t e;
        if (rst) begin
            prev_stall[d] = 1'b0;
            after_last[d] = 1'b0;
            return;
        end
        if (prev_stall[d]) chk("hold_under_backpressure", {valid, b}, {1'b1, prev_beat[d]});
        if (after_last[d]) begin
            if (done) begin
                after_last[d] = 1'b0;
            end else if (valid) begin
                chk("idle_cycles_between_frames", gap_seen[d], exp_gap[d]);
                after_last[d] = 1'b0;
            end else begin
                gap_seen[d]++;
            end
        end
        if (valid && rdy) begin
            hs_cnt[d]++;
            if ((d == 0 && q8.size() == 0) || (d == 1 && q32.size() == 0)) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat dut%0d: got beat %0h, expected no beat", d, b);
            end else begin
                if (d != 0) e = q32.pop_front();
                else        e = q8.pop_front();
                chk(d != 0 ? "beat32" : "beat8", b, e);
            end
            if (b.last) begin
                after_last[d] = 1'b1;
                gap_seen[d]   = 0;
            end
        end
        prev_stall[d] = valid && !rdy;
        prev_beat[d]  = b;
    endtask

    always @(negedge clk) begin
        mon(0, ax8.tvalid, ax8.tready, done8,
            {24'b0, ax8.tdata, 3'b0, ax8.tkeep, ax8.tlast, ax8.tuser});
        mon(1, ax32.tvalid, ax32.tready, done32,
            {ax32.tdata, ax32.tkeep, ax32.tlast, ax32.tuser});
    end

    task automatic step();
        @(posedge clk);
        #1;
        tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic wait_done(input int d, input int frames);
        int c;
        c = 0;
        while (!(d != 0 ? done32 : done8) && c < 4000) begin
            step();
            c++;
        end
        if (c >= 4000) begin
            tests++;
            fails++;
            $display("FAIL done_timeout dut%0d: got no done pulse, expected one", d);
        end
        chk("busy_at_done",   d != 0 ? busy32 : busy8, 0);
        chk("frames_sent",    d != 0 ? fs32 : fs8, frames);
        chk("scoreboard_empty", d != 0 ? q32.size() : q8.size(), 0);
        bp     = 1'b0;
        tready = 1'b1;
        step();
        chk("done_one_cycle", d != 0 ? done32 : done8, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int d;
        d = v.w32 ? 1 : 0;
        cfg_frame_len   = 16'(v.len);
        cfg_frame_count = 16'(v.count);
        cfg_gap         = 8'(v.gap);
        cfg_seed        = 8'(v.seed);
        cfg_mark_bad    = v.mark;
        exp_gap[d]      = v.gap;
        hs_cnt[d]       = 0;
        push_run(d, v.len, v.count, v.seed, v.mark);
        if (d != 0) start32 = 1'b1;
        else        start8  = 1'b1;
        stop = v.stp;
        bp   = v.bp;
        step();
        start8  = 1'b0;
        start32 = 1'b0;
        stop    = 1'b0;
        // Configuration must have been captured at start.
        cfg_seed      = ~cfg_seed;
        cfg_frame_len = cfg_frame_len + 16'd3;
        cfg_mark_bad  = ~cfg_mark_bad;
        chk("first_beat_next_cycle", d != 0 ? ax32.tvalid : ax8.tvalid, 1);
        chk("busy_next_cycle",       d != 0 ? busy32 : busy8, 1);
        wait_done(d, v.count);
        step();
    endtask

    vec_t vecs[10];

    initial begin
        int c;
        //            len cnt gap seed  mark w32 bp stp
        vecs[0] = '{  4,  2,  0, 'h10, 0,   0,  0, 0};
        vecs[1] = '{  6,  1,  0, 'h00, 0,   1,  0, 0};
        vecs[2] = '{  5,  3,  0, 'h20, 0,   0,  1, 0};
        vecs[3] = '{  5,  3,  0, 'h20, 0,   1,  1, 0};
        vecs[4] = '{  3,  3,  3, 'hFE, 1,   0,  0, 0};
        vecs[5] = '{  9,  2,  2, 'h80, 1,   1,  1, 0};
        vecs[6] = '{  4,  2,  0, 'hFF, 0,   1,  0, 0};
        vecs[7] = '{  1,  3,  1, 'h33, 1,   1,  1, 0};
        vecs[8] = '{  1,  2,  0, 'h00, 1,   0,  0, 0};
        vecs[9] = '{  3,  2,  0, 'h05, 0,   0,  0, 1};

        rst = 1'b1; start8 = 1'b0; start32 = 1'b0; stop = 1'b0; tready = 1'b1; bp = 1'b0;
        cfg_frame_len = '0; cfg_frame_count = '0; cfg_gap = '0; cfg_seed = '0; cfg_mark_bad = 1'b0;
        repeat (3) step();
        chk("rst_tvalid8",  ax8.tvalid, 0);
        chk("rst_tkeep8",   ax8.tkeep, 1'b1);
        chk("rst_tkeep32",  ax32.tkeep, 4'hF);
        chk("rst_tdata32",  ax32.tdata, 0);
        chk("rst_tlast32",  {ax32.tlast, ax32.tuser}, 0);
        chk("rst_status8",  {busy8, done8, fs8}, 0);
        chk("rst_status32", {busy32, done32, fs32}, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Zero-length start is ignored.
        cfg_frame_len = 16'd0; cfg_frame_count = 16'd1;
        start8 = 1'b1; step(); start8 = 1'b0; step();
        chk("len0_not_busy",  busy8, 0);
        chk("len0_no_tvalid", ax8.tvalid, 0);

        // Continuous run, stop inside frame 2, restart attempt while busy.
        cfg_frame_len = 16'd8; cfg_frame_count = 16'd0; cfg_gap = 8'd0;
        cfg_seed = 8'h50; cfg_mark_bad = 1'b0;
        exp_gap[0] = 0; hs_cnt[0] = 0;
        push_run(0, 8, 3, 'h50, 0);
        start8 = 1'b1; step(); start8 = 1'b0;
        cfg_seed = 8'h00; cfg_frame_len = 16'd2;
        c = 0;
        while (hs_cnt[0] < 19 && c < 500) begin step(); c++; end
        start8 = 1'b1; stop = 1'b1; step(); start8 = 1'b0; stop = 1'b0;
        wait_done(0, 3);

        // Stop while idling between frames.
        cfg_frame_len = 16'd2; cfg_frame_count = 16'd0; cfg_gap = 8'd5; cfg_seed = 8'h60;
        exp_gap[0] = 5;
        push_run(0, 2, 1, 'h60, 0);
        start8 = 1'b1; step(); start8 = 1'b0;
        c = 0;
        while (fs8 != 16'd1 && c < 100) begin step(); c++; end
        chk("gap_entered", fs8, 1);
        stop = 1'b1; step(); stop = 1'b0;
        chk("stop_gap_done",   done8, 1);
        chk("stop_gap_busy",   busy8, 0);
        chk("stop_gap_tvalid", ax8.tvalid, 0);
        chk("stop_gap_sb",     q8.size(), 0);
        step();
        chk("stop_gap_done_clear", done8, 0);

        // Reset in the middle of the second frame.
        cfg_frame_len = 16'd8; cfg_frame_count = 16'd0; cfg_gap = 8'd0; cfg_seed = 8'h40;
        exp_gap[0] = 0; hs_cnt[0] = 0;
        push_run(0, 8, 2, 'h40, 0);
        start8 = 1'b1; step(); start8 = 1'b0;
        c = 0;
        while (hs_cnt[0] < 12 && c < 200) begin step(); c++; end
        chk("pre_reset_frames", fs8, 1);
        rst = 1'b1; step();
        chk("mid_reset_tvalid", ax8.tvalid, 0);
        chk("mid_reset_frames", fs8, 0);
        chk("mid_reset_busy",   busy8, 0);
        rst = 1'b0;
        q8.delete();
        step();
        run_vec('{len: 8, count: 1, gap: 0, seed: 'h40, mark: 0, w32: 0, bp: 0, stp: 0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
